press_decoder: RTL



---
 rtl/press_decoder_pkg.sv | 18 +
 rtl/press_decoder_cycle_counter.sv | 29 ++
 rtl/press_decoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/press_decoder_pkg.sv
// Shared state encoding and default timing constants for the press decoder.
package press_decoder_pkg;

    // Gesture classifier states, 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } state_t;

    // Default timing, shared by the top level and the bench.
    localparam int LONG_CYCLES_DEFAULT = 50;
    localparam int GAP_CYCLES_DEFAULT  = 20;
    localparam int CNT_W_DEFAULT       = 16;

endpackage

// File: rtl/press_decoder_cycle_counter.sv
// Sample counter shared by the press and gap phases: load-1, increment,
// and a compare against a caller-supplied terminal value.
module cycle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_one,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    logic [CNT_W-1:0] count_reg;

    // Load-1 wins over increment; the first counted sample is the one that loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load_one) begin
            count_reg <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign at_term = (count_reg == term);

endmodule

// File: rtl/press_decoder.sv
// Classifies a debounced button level into short, double and long press
// pulses, plus a level that stays high while a long press is held.
module press_decoder
    import press_decoder_pkg::*;
#(
    parameter int LONG_CYCLES = LONG_CYCLES_DEFAULT,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic button_debounced,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic held
);

    // Terminal counts: the deciding sample is the one seen while the counter
    // already holds N-1, so the N-th sample makes the decision.
    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CYCLES - 1);

    state_t           state_reg;
    logic             short_press_reg;
    logic             double_press_reg;
    logic             long_press_reg;
    logic             held_reg;

    logic             cnt_load_one;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt_term;
    logic             cnt_at_term;

    // Counter control: load on the first sample of a phase, count while the
    // phase continues, and stop at the terminal so the count never wraps.
    always_comb begin
        cnt_load_one = 1'b0;
        cnt_inc      = 1'b0;
        cnt_term     = LONG_TERM;
        case (state_reg)
            IDLE: begin
                cnt_load_one = button_debounced;
            end
            PRESS1: begin
                if (button_debounced) begin
                    cnt_inc = !cnt_at_term;
                end else begin
                    cnt_load_one = 1'b1;
                end
            end
            WAIT2: begin
                cnt_term = GAP_TERM;
                if (!button_debounced) begin
                    cnt_inc = !cnt_at_term;
                end
            end
            default: begin
            end
        endcase
    end

    cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .clk      (clk),
        .reset    (reset),
        .load_one (cnt_load_one),
        .inc      (cnt_inc),
        .term     (cnt_term),
        .at_term  (cnt_at_term)
    );

    // Gesture FSM with registered one-cycle pulses and the held level.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            short_press_reg  <= 1'b0;
            double_press_reg <= 1'b0;
            long_press_reg   <= 1'b0;
            held_reg         <= 1'b0;
        end else begin
            short_press_reg  <= 1'b0;
            double_press_reg <= 1'b0;
            long_press_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (button_debounced) begin
                        state_reg <= PRESS1;
                    end
                end
                PRESS1: begin
                    if (button_debounced && cnt_at_term) begin
                        long_press_reg <= 1'b1;
                        held_reg       <= 1'b1;
                        state_reg      <= LONG_HOLD;
                    end else if (!button_debounced) begin
                        state_reg <= WAIT2;
                    end
                end
                WAIT2: begin
                    if (button_debounced) begin
                        double_press_reg <= 1'b1;
                        state_reg        <= PRESS2;
                    end else if (cnt_at_term) begin
                        short_press_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end
                end
                PRESS2: begin
                    // Second press length is deliberately ignored.
                    if (!button_debounced) begin
                        state_reg <= IDLE;
                    end
                end
                LONG_HOLD: begin
                    if (!button_debounced) begin
                        held_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    held_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign short_press  = short_press_reg;
    assign double_press = double_press_reg;
    assign long_press   = long_press_reg;
    assign held         = held_reg;

endmodule
